// File: rtl/ws2812_pkg.sv
// Shared types and 200 MHz timing defaults for the WS2812 multi-channel encoder.
package ws2812_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BIT   = 2'd1,
        ST_LATCH = 2'd2
    } state_e;

    localparam int unsigned CNT_T0H_200M    = 70;
    localparam int unsigned CNT_T1H_200M    = 140;
    localparam int unsigned CNT_PERIOD_200M = 250;
    localparam int unsigned CNT_RST_200M    = 60000;

    // Cycle count for a duration in ns at a clock in MHz, rounded to nearest.
    function automatic int unsigned ns_to_cnt(input int unsigned ns, input int unsigned clk_mhz);
        return (ns * clk_mhz + 500) / 1000;
    endfunction

endpackage

// File: rtl/ws2812_multi_out_edge2en.sv
// Registered falling-edge detector: one-cycle pulse after sig_i drops.
module edge2en (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic sig_i,
    output logic fall_o
);

    logic sig_q;
    logic fall_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sig_q  <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sig_q  <= sig_i;
            fall_q <= sig_q & ~sig_i;
        end
    end

    assign fall_o = fall_q;

endmodule

// File: rtl/ws2812_multi_out.sv
// Multi-channel WS2812 encoder: serialises pixel words MSB-first on CH_NUM strips
// in lockstep with a shared bit timer, plus a latch (reset) period on request.
module ws2812_multi_out
    import ws2812_pkg::*;
#(
    parameter int unsigned CH_NUM     = 8,
    parameter int unsigned BIT_NUM    = 24,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned CNT_T0H    = CNT_T0H_200M,
    parameter int unsigned CNT_T1H    = CNT_T1H_200M,
    parameter int unsigned CNT_PERIOD = CNT_PERIOD_200M,
    parameter int unsigned CNT_RST    = CNT_RST_200M
) (
    input  logic                        clk_in,
    input  logic                        rst_n_in,
    input  logic                        pixel_vld_in,
    input  logic [CH_NUM*BIT_NUM-1:0]   pixel_data_in,
    input  logic                        frame_end_in,
    output logic                        pixel_rdy_out,
    output logic                        busy_out,
    output logic                        frame_done_out,
    output logic [CH_NUM-1:0]           ws2812_data_out
);

    localparam int unsigned IDX_W = (BIT_NUM > 1) ? $clog2(BIT_NUM) : 1;

    if (!(CNT_T0H > 0 && CNT_T0H < CNT_T1H && CNT_T1H < CNT_PERIOD &&
          (CNT_RST >> CNT_W) == 0)) begin : g_param_check
        $error("ws2812_multi_out: illegal timing parameters");
    end

    state_e                         state_q, state_d;
    logic [CNT_W-1:0]               cyc_q, cyc_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic [CH_NUM-1:0][BIT_NUM-1:0] shift_q, shift_d;
    logic                           pend_q, pend_d;
    logic [CH_NUM-1:0]              data_q, data_d;
    logic                           busy_q;

    logic last_bit_c;
    logic rdy_c;
    logic accept_c;
    logic fe_acc_c;
    logic latch_nxt_c;

    assign last_bit_c = (state_q == ST_BIT) && (cyc_q == CNT_W'(CNT_PERIOD - 1)) && (idx_q == '0);
    assign rdy_c      = (state_q == ST_IDLE) || last_bit_c;
    assign accept_c   = pixel_vld_in && rdy_c;
    assign fe_acc_c   = frame_end_in && rdy_c;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= ST_IDLE;
            cyc_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            pend_q  <= 1'b0;
            data_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            pend_q  <= pend_d;
            data_q  <= data_d;
            busy_q  <= (state_q != ST_IDLE);
        end
    end

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        pend_d  = pend_q;
        data_d  = '0;

        if (accept_c) begin
            state_d = ST_BIT;
            cyc_d   = '0;
            idx_d   = IDX_W'(BIT_NUM - 1);
            shift_d = pixel_data_in;
            pend_d  = pend_q | frame_end_in;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (fe_acc_c) begin
                        state_d = ST_LATCH;
                        cyc_d   = '0;
                    end
                end
                ST_BIT: begin
                    if (cyc_q == CNT_W'(CNT_PERIOD - 1)) begin
                        cyc_d = '0;
                        if (idx_q == '0) begin
                            state_d = (pend_q || fe_acc_c) ? ST_LATCH : ST_IDLE;
                        end else begin
                            idx_d = idx_q - 1'b1;
                            for (int unsigned c = 0; c < CH_NUM; c++) begin
                                shift_d[c] = shift_q[c] << 1;
                            end
                        end
                    end else begin
                        cyc_d = cyc_q + 1'b1;
                    end
                end
                ST_LATCH: begin
                    if (cyc_q == CNT_W'(CNT_RST - 1)) begin
                        state_d = ST_IDLE;
                        cyc_d   = '0;
                        pend_d  = 1'b0;
                    end else begin
                        cyc_d = cyc_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Output is computed from next-cycle timer so the line aligns with cyc_cnt.
        for (int unsigned c = 0; c < CH_NUM; c++) begin
            data_d[c] = (state_d == ST_BIT) &&
                        (cyc_d < (shift_d[c][BIT_NUM-1] ? CNT_W'(CNT_T1H) : CNT_W'(CNT_T0H)));
        end
    end

    assign latch_nxt_c = (state_d == ST_LATCH);

    edge2en u_done (
        .clk_i   (clk_in),
        .rst_n_i (rst_n_in),
        .sig_i   (latch_nxt_c),
        .fall_o  (frame_done_out)
    );

    assign pixel_rdy_out   = rdy_c;
    assign busy_out        = busy_q;
    assign ws2812_data_out = data_q;

endmodule
